// File: rtl/sbqm_pkg.sv
// Shared constants and types for the bank queue occupancy
// and wait-time estimation stage.
package sbqm_pkg;

  localparam int DEF_PCOUNT_W     = 3;
  localparam int DEF_TCOUNT_W     = 2;
  localparam int DEF_WTIME_W      = 5;
  localparam int DEF_SERVICE_TIME = 3;

  localparam int PMAX = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DONE
  } div_state_t;

endpackage

// File: rtl/wait_time_divider.sv
// Sequential restoring divider, MSB first, one quotient
// bit per cycle, controlled by a four-state FSM.
module wait_time_divider
  import sbqm_pkg::*;
#(
  parameter int NUM_W = DEF_WTIME_W,
  parameter int DEN_W = DEF_TCOUNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quot,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(NUM_W + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_W - 1);

  div_state_t state;
  div_state_t state_n;

  logic [NUM_W-1:0] qr;
  logic [DEN_W-1:0] dr;
  logic [DEN_W-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic             ge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    state_n = DIV;
      DIV:     if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    trial = {rem, qr[NUM_W-1]};
    ge    = (trial >= {1'b0, dr});
    diff  = trial - {1'b0, dr};
  end

  // Operands are captured on entry to LOAD so that LOAD can
  // already retire the first quotient bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qr  <= '0;
      dr  <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            qr  <= num;
            dr  <= den;
            rem <= '0;
            cnt <= LAST;
          end
        end
        LOAD, DIV: begin
          qr  <= {qr[NUM_W-2:0], ge};
          rem <= ge ? diff[DEN_W-1:0]
                    : trial[DEN_W-1:0];
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quot = qr;

endmodule

// File: rtl/queue_counter.sv
// Saturating customer count with full/empty flags and a
// recompute tracker feeding the wait-time divider.
module queue_counter
  import sbqm_pkg::*;
#(
  parameter int PCOUNT_W     = DEF_PCOUNT_W,
  parameter int TCOUNT_W     = DEF_TCOUNT_W,
  parameter int SERVICE_TIME = DEF_SERVICE_TIME,
  parameter int WTIME_W      = DEF_WTIME_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up_pulse,
  input  logic                down_pulse,
  input  logic [TCOUNT_W-1:0] tcount,
  output logic [PCOUNT_W-1:0] pcount,
  output logic                full,
  output logic                empty,
  output logic [WTIME_W-1:0]  wtime,
  output logic                wtime_valid
);

  localparam int NW = 16;
  localparam logic [PCOUNT_W-1:0] CMAX = PCOUNT_W'(PMAX);

  logic                inc;
  logic                dec;
  logic                tchg;
  logic                change;
  logic                dirty;
  logic                busy;
  logic                div_done;
  logic [TCOUNT_W-1:0] tcount_q;
  logic [TCOUNT_W-1:0] teff;
  logic [NW-1:0]       sum;
  logic [WTIME_W-1:0]  num;
  logic [WTIME_W-1:0]  quot;

  function automatic logic [NW-1:0] scale(
    input logic [NW-1:0] x
  );
    logic [NW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NW; i++) begin
      if (SERVICE_TIME[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  always_comb begin
    full   = (pcount == CMAX);
    empty  = (pcount == '0);
    inc    = up_pulse & ~down_pulse & ~full;
    dec    = down_pulse & ~up_pulse & ~empty;
    tchg   = (tcount != tcount_q);
    change = inc | dec | tchg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcount   <= '0;
      tcount_q <= '0;
      dirty    <= 1'b0;
    end else begin
      tcount_q <= tcount;
      if (inc) begin
        pcount <= pcount + PCOUNT_W'(1);
      end else if (dec) begin
        pcount <= pcount - PCOUNT_W'(1);
      end
      // A change on the accepting edge keeps the request alive.
      if (change) begin
        dirty <= 1'b1;
      end else if (dirty && !busy) begin
        dirty <= 1'b0;
      end
    end
  end

  always_comb begin
    teff = (tcount_q == '0) ? TCOUNT_W'(1) : tcount_q;
    sum  = NW'(pcount) + NW'(teff) - NW'(1);
    num  = empty ? '0 : WTIME_W'(scale(sum));
  end

  wait_time_divider #(
    .NUM_W (WTIME_W),
    .DEN_W (TCOUNT_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (dirty),
    .num   (num),
    .den   (teff),
    .quot  (quot),
    .busy  (busy),
    .done  (div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wtime <= '0;
    end else if (div_done) begin
      wtime <= quot;
    end
  end

  assign wtime_valid = !busy && !dirty;

endmodule

// File: tb/tb_queue_counter.sv
// Self-checking bench: vector table, directed corner
// sequences and randomized traffic against a reference model.
module tb_queue_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up_pulse = 1'b0;
  logic       down_pulse = 1'b0;
  logic [1:0] tcount = 2'd0;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic [4:0] wtime;
  logic       wtime_valid;

  int checks = 0;
  int errors = 0;

  queue_counter dut (
    .clk         (clk),
    .reset       (reset),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .tcount      (tcount),
    .pcount      (pcount),
    .full        (full),
    .empty       (empty),
    .wtime       (wtime),
    .wtime_valid (wtime_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       down;
    logic [2:0] p;
    logic       f;
    logic       e;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    reset      = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    step();
  endtask

  function automatic int ref_wt(input int p, input int t);
    int te;
    te = (t == 0) ? 1 : t;
    if (p == 0) return 0;
    return (3 * (p + te - 1)) / te;
  endfunction

  int m_p;
  int samp_t;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    for (int i = 6; i <= 12; i++)
      tbl[i] = '{1'b1, 1'b0, 3'(i - 5), (i == 12), 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0};

    // reset state
    reset = 1'b0;
    #12;
    chk("rst_pcount", pcount, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wtime", wtime, 0);
    chk("rst_valid", wtime_valid, 1);
    step();
    reset = 1'b1;
    step();

    // table of count updates
    tcount = 2'd1;
    for (int i = 0; i < 16; i++) begin
      up_pulse   = tbl[i].up;
      down_pulse = tbl[i].down;
      step();
      up_pulse   = 1'b0;
      down_pulse = 1'b0;
      chk($sformatf("vec%0d", i),
          {pcount, full, empty},
          {tbl[i].p, tbl[i].f, tbl[i].e});
    end

    // three spaced arrivals, exact 7-edge latency
    do_reset();
    tcount = 2'd1;
    wait_cycles(12);
    for (int n = 1; n <= 3; n++) begin
      up_pulse = 1'b1;
      step();
      up_pulse = 1'b0;
      chk("a_pcount", pcount, n);
      if (n < 3) wait_cycles(10);
    end
    chk("a_empty", empty, 0);
    chk("a_valid_k", wtime_valid, 0);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j < 7) begin
        chk("a_valid_low", wtime_valid, 0);
        chk("a_wtime_old", wtime, 6);
      end else begin
        chk("a_wtime", wtime, 9);
        chk("a_valid", wtime_valid, 1);
      end
    end

    // teller count change 1 -> 2 -> 0
    tcount = 2'd2;
    step();
    chk("b_valid_k", wtime_valid, 0);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j < 7) begin
        chk("b_valid_low", wtime_valid, 0);
        chk("b_wtime_old", wtime, 9);
      end else begin
        chk("b_wtime", wtime, 6);
        chk("b_valid", wtime_valid, 1);
      end
    end
    tcount = 2'd0;
    wait_cycles(10);
    chk("b_wtime_t0", wtime, 9);
    chk("b_valid_t0", wtime_valid, 1);

    // saturation
    do_reset();
    tcount = 2'd3;
    up_pulse = 1'b1;
    wait_cycles(8);
    up_pulse = 1'b0;
    chk("c_pcount", pcount, 7);
    chk("c_full", full, 1);
    wait_cycles(20);
    chk("c_wtime", wtime, 9);
    chk("c_valid", wtime_valid, 1);

    // simultaneous pulses cause no recompute
    do_reset();
    tcount = 2'd1;
    up_pulse = 1'b1;
    wait_cycles(4);
    up_pulse = 1'b0;
    wait_cycles(20);
    chk("d_wtime", wtime, 12);
    up_pulse   = 1'b1;
    down_pulse = 1'b1;
    step();
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    chk("d_pcount", pcount, 4);
    chk("d_valid0", wtime_valid, 1);
    step();
    chk("d_valid1", wtime_valid, 1);

    // change arriving mid-computation
    do_reset();
    tcount = 2'd1;
    wait_cycles(10);
    up_pulse = 1'b1;
    step();
    up_pulse = 1'b0;
    wait_cycles(2);
    up_pulse = 1'b1;
    step();
    up_pulse = 1'b0;
    for (int j = 4; j <= 14; j++) begin
      step();
      if (j == 6) chk("e_wtime_k6", wtime, 0);
      if (j == 7) chk("e_wtime_k7", wtime, 3);
      if (j < 14) chk("e_valid_low", wtime_valid, 0);
      else begin
        chk("e_wtime", wtime, 6);
        chk("e_valid", wtime_valid, 1);
      end
    end

    // reset during the divide
    do_reset();
    tcount = 2'd1;
    up_pulse = 1'b1;
    wait_cycles(5);
    up_pulse = 1'b0;
    wait_cycles(20);
    chk("f_wtime_pre", wtime, 15);
    tcount = 2'd2;
    wait_cycles(4);
    reset = 1'b0;
    #1;
    chk("f_pcount", pcount, 0);
    chk("f_wtime", wtime, 0);
    chk("f_valid", wtime_valid, 1);
    chk("f_empty", empty, 1);
    step();
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      chk("f_no_stale", wtime, 0);
    end
    chk("f_valid_end", wtime_valid, 1);

    // randomized traffic against the reference model
    do_reset();
    m_p    = 0;
    samp_t = int'(tcount);
    for (int i = 0; i < 800; i++) begin
      if ((i % 40) < 24) begin
        up_pulse   = ($urandom_range(0, 2) == 0);
        down_pulse = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0)
          tcount = 2'($urandom_range(0, 3));
      end
      if (up_pulse && !down_pulse && m_p < 7)
        m_p++;
      else if (down_pulse && !up_pulse && m_p > 0)
        m_p--;
      samp_t = int'(tcount);
      step();
      up_pulse   = 1'b0;
      down_pulse = 1'b0;
      chk("r_pcount", pcount, m_p);
      chk("r_flags", {full, empty},
          {(m_p == 7), (m_p == 0)});
      if (wtime_valid)
        chk("r_wtime", wtime, ref_wt(m_p, samp_t));
      if ((i % 40) == 39)
        chk("r_settled", wtime_valid, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
